mq_outport_aggregator: RTL and testbench
========================================

Name: mq_outport_aggregator

Overview:
- Successor to the 4-in/4-out aggregator, parametrised in input-queue count, output-port count, FIFO depth and port-selection mode.
- Round-robins packets from NUM_IN_QUEUES buffered input queues onto one of NUM_OUT_PORTS output ports.
- The output port is chosen per packet by a mode input: fixed, per-packet round-robin, or first-ready. The choice is locked for the whole packet.
- Sits between the user datapath stages and the TX output queues.

Parameters:
- DATA_WIDTH, 64, data word width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl word width.
- NUM_IN_QUEUES, 4, number of input queues (>=2).
- NUM_OUT_PORTS, 4, number of output ports (>=2).
- FIFO_DEPTH_BITS, 2, log2 depth of each input FIFO.
- STAGE_NUMBER, 2, nonzero ctrl seed value for the packet-tracking register.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN_QUEUES*DATA_WIDTH  queue q occupies bits [q*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl  in  NUM_IN_QUEUES*CTRL_WIDTH  per-queue ctrl.
- in_wr  in  NUM_IN_QUEUES  per-queue write strobe.
- in_rdy  out  NUM_IN_QUEUES  per-queue ready; equals !nearly_full of that FIFO.
- out_data  out  DATA_WIDTH  shared by all ports.
- out_ctrl  out  CTRL_WIDTH  shared by all ports.
- out_wr  out  NUM_OUT_PORTS  one-hot (or zero) write strobe.
- out_rdy  in  NUM_OUT_PORTS  per-port ready.
- sel_mode  in  2  0 = fixed, 1 = packet round-robin, 2 = first-ready, 3 = fixed (treated as 0).
- fixed_port  in  log2(NUM_OUT_PORTS)  target port in fixed mode; values >= NUM_OUT_PORTS map to port 0.
- pkt_done  out  1  one-cycle pulse when the eop word is written.
- pkt_done_port  out  log2(NUM_OUT_PORTS)  port of the completed packet; valid with pkt_done.
- pkt_done_queue  out  log2(NUM_IN_QUEUES)  source queue of the completed packet; valid with pkt_done.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - out_wr = 0, out_ctrl = 1, out_data = 0.
  - pkt_done = 0; pkt_done_port and pkt_done_queue = 0.
  - state = IDLE, cur_queue = 0, rr_port = 0, ctrl_prev = 1.
  - All FIFOs empty.
- Input FIFOs:
  - Each is depth 2^FIFO_DEPTH_BITS with registered output (read data valid the cycle after rd_en).
  - A write while full is a protocol violation; the content afterwards is unspecified.
- Packet framing:
  - Header words have ctrl != 0; body words have ctrl == 0.
  - eop is the first ctrl != 0 word that follows a ctrl == 0 word.
- IDLE state:
  - Resolve the candidate port p from sel_mode:
    - fixed: p = fixed_port.
    - round-robin: p = rr_port.
    - first-ready: p = the lowest index with out_rdy set, searching upward from rr_port with wrap.
  - If !empty[cur_queue] and out_rdy[p]: latch p into lock_port, assert rd_en[cur_queue], set ctrl_prev = STAGE_NUMBER, go to WR_PKT.
  - If empty[cur_queue] and out_rdy[p]: cur_queue advances by 1, wrapping from NUM_IN_QUEUES-1 to 0.
  - If out_rdy[p] = 0: hold state and cur_queue.
- WR_PKT state:
  - Only lock_port is used. sel_mode and fixed_port changes take effect at the next packet only.
  - If out_rdy[lock_port], fifo ctrl != 0 and ctrl_prev == 0 (eop): write the word, return to IDLE, advance cur_queue.
    - rr_port advances with wrap in round-robin and first-ready modes only (first-ready: rr_port = lock_port + 1).
    - pkt_done pulses one cycle later, aligned with that out_wr.
  - Else if out_rdy[lock_port] and !empty[cur_queue]: write the word, read the next word, ctrl_prev = current ctrl.
  - Otherwise stall: no write, no read, all state held.
- Output timing:
  - Output is registered: out_wr[lock_port] asserts one cycle after the write decision, with matching out_data and out_ctrl.
  - All other out_wr bits are 0.
- Throughput: one word per cycle while ready. Minimum per-packet overhead is one IDLE cycle plus FIFO read latency.
- Fairness: packet-granular round-robin over input queues; an empty queue costs one cycle to skip.
- Simultaneous events:
  - An input write to the queue being read in the same cycle is legal.
  - out_rdy dropping in the same cycle as eop blocks the eop write until out_rdy returns.
- Reset mid-packet: the partial packet is discarded. No further out_wr until a new packet reaches the head of a queue.

Test Plan:
- Mode 0, fixed_port = 2; 3-word packet (ctrl 0xFF, 0x00, 0x10) on queue 0 -> only out_wr[2] pulses 3 cycles; pkt_done with port 2, queue 0.
- Mode 1; one packet on each of queues 0..3 -> packets emerge in queue order 0,1,2,3 on ports 0,1,2,3; rr_port = 0 after the fourth.
- Mode 2; out_rdy = 4'b1010, rr_port = 0 -> packet goes to port 1; rr_port becomes 2.
- Mode 0; change fixed_port from 0 to 3 mid-packet -> remainder of the packet stays on port 0; the next packet goes to port 3.
- Deassert out_rdy[lock_port] for 5 cycles mid-packet -> no out_wr during the stall; no word lost or duplicated; data order preserved.
- Assert reset for 1 cycle mid-packet -> all outputs at reset values next cycle; a subsequent new packet transfers cleanly from queue 0.

Source files
------------

// File: rtl/mq_outport_aggregator_if.sv
// Bus bundle for mq_outport_aggregator: input queues, output ports,
// port-selection controls and packet-completion report.
interface mq_outport_aggregator_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int NUM_IN_QUEUES = 4,
    parameter int NUM_OUT_PORTS = 4
);
    localparam int PW = $clog2(NUM_OUT_PORTS);
    localparam int QW = $clog2(NUM_IN_QUEUES);

    logic [NUM_IN_QUEUES*DATA_WIDTH-1:0] in_data;
    logic [NUM_IN_QUEUES*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_IN_QUEUES-1:0]            in_wr;
    logic [NUM_IN_QUEUES-1:0]            in_rdy;
    logic [DATA_WIDTH-1:0]               out_data;
    logic [CTRL_WIDTH-1:0]               out_ctrl;
    logic [NUM_OUT_PORTS-1:0]            out_wr;
    logic [NUM_OUT_PORTS-1:0]            out_rdy;
    logic [1:0]                          sel_mode;
    logic [PW-1:0]                       fixed_port;
    logic                                pkt_done;
    logic [PW-1:0]                       pkt_done_port;
    logic [QW-1:0]                       pkt_done_queue;

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy, sel_mode, fixed_port,
        output in_rdy, out_data, out_ctrl, out_wr,
        output pkt_done, pkt_done_port, pkt_done_queue
    );

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy, sel_mode, fixed_port,
        input  in_rdy, out_data, out_ctrl, out_wr,
        input  pkt_done, pkt_done_port, pkt_done_queue
    );
endinterface

// File: rtl/mq_outport_aggregator.sv
// Round-robin aggregator from N buffered input queues onto M output
// ports; the output port is chosen per packet and locked until eop.
module mq_outport_aggregator #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_IN_QUEUES   = 4,
    parameter int NUM_OUT_PORTS   = 4,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int STAGE_NUMBER    = 2
) (
    input logic                   clk,
    input logic                   reset,
    mq_outport_aggregator_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int AW    = FIFO_DEPTH_BITS;
    localparam int CW    = FIFO_DEPTH_BITS + 1;
    localparam int W     = DATA_WIDTH + CTRL_WIDTH;
    localparam int PW    = $clog2(NUM_OUT_PORTS);
    localparam int QW    = $clog2(NUM_IN_QUEUES);

    typedef enum logic {IDLE, WR_PKT} state_t;

    state_t state, state_next;

    logic [NUM_IN_QUEUES-1:0][W-1:0] head;
    logic [NUM_IN_QUEUES-1:0]        empty;
    logic [NUM_IN_QUEUES-1:0]        rd_en;

    genvar q;
    generate
        for (q = 0; q < NUM_IN_QUEUES; q++) begin : g_fifo
            logic [W-1:0]  mem [DEPTH];
            logic [AW-1:0] wptr;
            logic [AW-1:0] rptr;
            logic [CW-1:0] count;
            logic [W-1:0]  rdata;

            // storage array, no reset needed
            always_ff @(posedge clk) begin
                if (bus.in_wr[q])
                    mem[wptr] <= {bus.in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH],
                                  bus.in_data[q*DATA_WIDTH +: DATA_WIDTH]};
            end

            // pointers, occupancy and registered read port
            always_ff @(posedge clk) begin
                if (reset) begin
                    wptr  <= '0;
                    rptr  <= '0;
                    count <= '0;
                    rdata <= '0;
                end else begin
                    if (bus.in_wr[q])
                        wptr <= wptr + AW'(1);
                    if (rd_en[q]) begin
                        rdata <= mem[rptr];
                        rptr  <= rptr + AW'(1);
                    end
                    count <= count + CW'(bus.in_wr[q]) - CW'(rd_en[q]);
                end
            end

            assign empty[q]      = (count == '0);
            assign bus.in_rdy[q] = (count < CW'(DEPTH - 1));
            assign head[q]       = rdata;
        end
    endgenerate

    logic [QW-1:0]         cur_queue;
    logic [PW-1:0]         rr_port;
    logic [PW-1:0]         lock_port;
    logic                  lock_rr;
    logic [CTRL_WIDTH-1:0] ctrl_prev;
    logic [W-1:0]          cur_word;
    logic [CTRL_WIDTH-1:0] cur_ctrl;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [PW-1:0]         fr_port;
    logic [PW-1:0]         idx;
    logic [PW-1:0]         cand;
    logic [QW-1:0]         queue_next;
    logic [PW-1:0]         port_next;
    logic                  take, skip, do_wr, do_eop;

    logic [NUM_OUT_PORTS-1:0] wr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [CTRL_WIDTH-1:0]    ctrl_q;
    logic                     done_q;
    logic [PW-1:0]            done_port_q;
    logic [QW-1:0]            done_queue_q;

    assign cur_word   = head[cur_queue];
    assign cur_ctrl   = cur_word[W-1 -: CTRL_WIDTH];
    assign cur_data   = cur_word[DATA_WIDTH-1:0];
    assign queue_next = (cur_queue == QW'(NUM_IN_QUEUES - 1)) ?
                        '0 : cur_queue + QW'(1);
    assign port_next  = (lock_port == PW'(NUM_OUT_PORTS - 1)) ?
                        '0 : lock_port + PW'(1);

    // first ready port at or after rr_port; descending scan so the
    // nearest match is the one left standing
    always_comb begin
        fr_port = rr_port;
        idx     = '0;
        for (int i = NUM_OUT_PORTS - 1; i >= 0; i--) begin
            idx = PW'((int'(rr_port) + i) % NUM_OUT_PORTS);
            if (bus.out_rdy[idx])
                fr_port = idx;
        end
    end

    // candidate port for the next packet
    always_comb begin
        cand = '0;
        case (bus.sel_mode)
            2'd1:    cand = rr_port;
            2'd2:    cand = fr_port;
            default: cand = (int'(bus.fixed_port) < NUM_OUT_PORTS) ?
                            bus.fixed_port : '0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next state, FIFO read and write decisions
    always_comb begin
        state_next = state;
        rd_en      = '0;
        take       = 1'b0;
        skip       = 1'b0;
        do_wr      = 1'b0;
        do_eop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.out_rdy[cand]) begin
                    if (!empty[cur_queue]) begin
                        rd_en[cur_queue] = 1'b1;
                        take             = 1'b1;
                        state_next       = WR_PKT;
                    end else begin
                        skip = 1'b1;
                    end
                end
            end
            WR_PKT: begin
                if (bus.out_rdy[lock_port]) begin
                    if (cur_ctrl != '0 && ctrl_prev == '0) begin
                        do_wr      = 1'b1;
                        do_eop     = 1'b1;
                        state_next = IDLE;
                    end else if (!empty[cur_queue]) begin
                        do_wr            = 1'b1;
                        rd_en[cur_queue] = 1'b1;
                    end
                end
            end
        endcase
    end

    // arbitration state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_queue    <= '0;
            rr_port      <= '0;
            lock_port    <= '0;
            lock_rr      <= 1'b0;
            ctrl_prev    <= CTRL_WIDTH'(1);
            wr_q         <= '0;
            data_q       <= '0;
            ctrl_q       <= CTRL_WIDTH'(1);
            done_q       <= 1'b0;
            done_port_q  <= '0;
            done_queue_q <= '0;
        end else begin
            if (take) begin
                lock_port <= cand;
                lock_rr   <= (bus.sel_mode == 2'd1) || (bus.sel_mode == 2'd2);
                ctrl_prev <= CTRL_WIDTH'(STAGE_NUMBER);
            end
            if (do_wr && !do_eop)
                ctrl_prev <= cur_ctrl;
            if (skip || do_eop)
                cur_queue <= queue_next;
            if (do_eop && lock_rr)
                rr_port <= port_next;
            wr_q <= do_wr ? (NUM_OUT_PORTS'(1) << lock_port) : '0;
            if (do_wr) begin
                data_q <= cur_data;
                ctrl_q <= cur_ctrl;
            end
            done_q <= do_eop;
            if (do_eop) begin
                done_port_q  <= lock_port;
                done_queue_q <= cur_queue;
            end
        end
    end

    assign bus.out_wr         = wr_q;
    assign bus.out_data       = data_q;
    assign bus.out_ctrl       = ctrl_q;
    assign bus.pkt_done       = done_q;
    assign bus.pkt_done_port  = done_port_q;
    assign bus.pkt_done_queue = done_queue_q;
endmodule

// File: tb/tb_mq_outport_aggregator.sv
// Scoreboard bench for mq_outport_aggregator: stimulus pushes expected
// words and completions, a negedge monitor pops and compares them.
module tb_mq_outport_aggregator;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;
    localparam int NP = 4;

    typedef struct packed {
        logic [1:0]  port;
        logic [7:0]  ctrl;
        logic [63:0] data;
    } word_t;

    typedef struct packed {
        logic [1:0] port;
        logic [1:0] queue;
    } done_t;

    logic clk = 1'b0;
    logic reset;
    word_t exp_w[$];
    done_t exp_d[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mq_outport_aggregator_if #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW),
        .NUM_IN_QUEUES(NQ), .NUM_OUT_PORTS(NP)
    ) bus ();

    mq_outport_aggregator #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW),
        .NUM_IN_QUEUES(NQ), .NUM_OUT_PORTS(NP),
        .FIFO_DEPTH_BITS(2), .STAGE_NUMBER(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor: every output write and completion must match the queue head
    always @(negedge clk) begin
        if (bus.out_wr != '0) begin
            if (exp_w.size() == 0) begin
                check("unexpected_wr", 64'(bus.out_wr), 64'd0);
            end else begin
                word_t e;
                e = exp_w.pop_front();
                check("out_wr", 64'(bus.out_wr), 64'(4'b0001 << e.port));
                check("out_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
                check("out_data", bus.out_data, e.data);
            end
        end
        if (bus.pkt_done) begin
            if (exp_d.size() == 0) begin
                check("unexpected_done", 64'(bus.pkt_done), 64'd0);
            end else begin
                done_t d;
                d = exp_d.pop_front();
                check("done_port", 64'(bus.pkt_done_port), 64'(d.port));
                check("done_queue", 64'(bus.pkt_done_queue), 64'(d.queue));
                check("done_align", 64'(bus.out_wr), 64'(4'b0001 << d.port));
            end
        end
    end

    task automatic send(int q, logic [7:0] c, logic [63:0] d);
        bus.in_wr = 4'(1) << q;
        bus.in_ctrl[q*CW +: CW] = c;
        bus.in_data[q*DW +: DW] = d;
        @(posedge clk);
        #1;
        bus.in_wr = '0;
    endtask

    // 3-word packet: header, body, eop
    task automatic pkt(int q, int port, logic [63:0] base);
        exp_w.push_back('{port: 2'(port), ctrl: 8'hFF, data: base});
        exp_w.push_back('{port: 2'(port), ctrl: 8'h00, data: base + 1});
        exp_w.push_back('{port: 2'(port), ctrl: 8'h10, data: base + 2});
        exp_d.push_back('{port: 2'(port), queue: 2'(q)});
        send(q, 8'hFF, base);
        send(q, 8'h00, base + 1);
        send(q, 8'h10, base + 2);
    endtask

    task automatic rst();
        bus.out_rdy = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while ((exp_w.size() != 0 || exp_d.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(exp_w.size() + exp_d.size()), 64'd0);
    endtask

    task automatic wait_wr(string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.out_wr == '0 && n < 100);
        check(name, 64'(bus.out_wr != '0), 64'd1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_out_wr"}, 64'(bus.out_wr), 64'd0);
        check({tag, "_out_ctrl"}, 64'(bus.out_ctrl), 64'd1);
        check({tag, "_out_data"}, bus.out_data, 64'd0);
        check({tag, "_pkt_done"}, 64'(bus.pkt_done), 64'd0);
        check({tag, "_done_port"}, 64'(bus.pkt_done_port), 64'd0);
        check({tag, "_done_queue"}, 64'(bus.pkt_done_queue), 64'd0);
        check({tag, "_in_rdy"}, 64'(bus.in_rdy), 64'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        bus.in_wr      = '0;
        bus.in_data    = '0;
        bus.in_ctrl    = '0;
        bus.out_rdy    = '0;
        bus.sel_mode   = 2'd0;
        bus.fixed_port = '0;
        reset          = 1'b1;
        rst();

        // reset values
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;

        // fixed mode, port 2
        rst();
        bus.sel_mode   = 2'd0;
        bus.fixed_port = 2'd2;
        pkt(0, 2, 64'h100);
        bus.out_rdy = '1;
        drain("fixed_drain");

        // packet round-robin across queues 0..3, then wrap to port 0
        rst();
        bus.sel_mode = 2'd1;
        pkt(0, 0, 64'h200);
        pkt(1, 1, 64'h210);
        pkt(2, 2, 64'h220);
        pkt(3, 3, 64'h230);
        bus.out_rdy = '1;
        drain("rr_drain");
        bus.out_rdy = '0;
        pkt(2, 0, 64'h240);
        bus.out_rdy = '1;
        drain("rr_wrap_drain");

        // first-ready: 1010 from rr 0 picks port 1, rr moves to 2
        rst();
        bus.sel_mode = 2'd2;
        pkt(0, 1, 64'h300);
        bus.out_rdy = 4'b1010;
        drain("fr_drain");
        bus.out_rdy = '0;
        pkt(2, 2, 64'h310);
        bus.out_rdy = '1;
        drain("fr_next_drain");

        // fixed_port change mid-packet only affects the next packet
        rst();
        bus.sel_mode   = 2'd0;
        bus.fixed_port = 2'd0;
        pkt(0, 0, 64'h400);
        pkt(1, 3, 64'h410);
        bus.out_rdy = '1;
        wait_wr("fixchg_first");
        bus.fixed_port = 2'd3;
        @(posedge clk);
        #1;
        drain("fixchg_drain");

        // stall on the locked port for 5 cycles
        rst();
        bus.fixed_port = 2'd1;
        pkt(0, 1, 64'h500);
        bus.out_rdy = '1;
        wait_wr("stall_first");
        bus.out_rdy = 4'b1101;
        repeat (5) begin
            @(negedge clk);
            check("stall_no_wr", 64'(bus.out_wr), 64'd0);
        end
        bus.out_rdy = '1;
        @(posedge clk);
        #1;
        drain("stall_drain");

        // reset mid-packet discards the rest
        rst();
        bus.fixed_port = 2'd0;
        pkt(0, 0, 64'h600);
        bus.out_rdy = '1;
        wait_wr("midrst_first");
        reset       = 1'b1;
        bus.out_rdy = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_w.delete();
        exp_d.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        pkt(0, 0, 64'h700);
        bus.out_rdy = '1;
        drain("midrst_drain");

        check("final_empty", 64'(exp_w.size() + exp_d.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
